// File: rtl/exec_pkg.sv
// Shared encodings for the RV32I execute stage: ALU ops, forward selects, branch conditions.
package exec_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD   = 4'b0000;
    localparam alu_op_t ALU_SUB   = 4'b0001;
    localparam alu_op_t ALU_AND   = 4'b0010;
    localparam alu_op_t ALU_OR    = 4'b0011;
    localparam alu_op_t ALU_XOR   = 4'b0100;
    localparam alu_op_t ALU_SLL   = 4'b0101;
    localparam alu_op_t ALU_SRL   = 4'b0110;
    localparam alu_op_t ALU_SRA   = 4'b0111;
    localparam alu_op_t ALU_SLT   = 4'b1000;
    localparam alu_op_t ALU_SLTU  = 4'b1001;
    localparam alu_op_t ALU_PASSB = 4'b1010;

    localparam logic [1:0] FWD_RD = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/exec_alu.sv
// Combinational RV32I ALU with equality and signed/unsigned less-than flags on a vs b.
module exec_alu
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         op,
    output logic [XLEN-1:0] y,
    output logic            zero,
    output logic            lt,
    output logic            ltu
);

    logic [4:0] w_shamt;

    assign w_shamt = b[4:0];
    assign zero    = (a == b);
    assign lt      = ($signed(a) < $signed(b));
    assign ltu     = (a < b);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_SLL:   y = a << w_shamt;
            ALU_SRL:   y = a >> w_shamt;
            ALU_SRA:   y = $signed(a) >>> w_shamt;
            ALU_SLT:   y = {{(XLEN-1){1'b0}}, lt};
            ALU_SLTU:  y = {{(XLEN-1){1'b0}}, ltu};
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/execute_cycle.sv
// EX stage: forwarding muxes, ALU, branch/jump resolution and the EX/MEM register.
// Define EXEC_PERF_CNT_EN to add the BranchCnt/TakenCnt performance counters.
module execute_cycle
    import exec_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC_M = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            MemReadE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic [3:0]      ALUControlE,
    input  logic [2:0]      funct3_E,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic            StallM,
    input  logic            FlushM,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            MemReadM,
    output logic            ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RD_M,
    output logic [2:0]      funct3_M
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0]     BranchCnt,
    output logic [31:0]     TakenCnt
`endif
);

    logic [XLEN-1:0] w_src_a, w_write_data, w_src_b, w_alu_y, w_cmp_y, w_jalr_sum;
    logic            w_alu_zero, w_alu_lt, w_alu_ltu;
    logic            w_eq, w_lt, w_ltu, w_taken;
    logic            w_unused;

    logic            r_regwrite_m, r_memwrite_m, r_memread_m, r_resultsrc_m;
    logic [XLEN-1:0] r_aluresult_m, r_writedata_m, r_pcplus4_m;
    logic [4:0]      r_rd_m;
    logic [2:0]      r_funct3_m;

    always_comb begin
        case (ForwardAE)
            FWD_W:   w_src_a = ResultW;
            FWD_M:   w_src_a = r_aluresult_m;
            default: w_src_a = RD1_E;
        endcase
        case (ForwardBE)
            FWD_W:   w_write_data = ResultW;
            FWD_M:   w_write_data = r_aluresult_m;
            default: w_write_data = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_write_data;

    exec_alu #(.XLEN(XLEN)) u_alu (
        .a    (w_src_a),
        .b    (w_src_b),
        .op   (ALUControlE),
        .y    (w_alu_y),
        .zero (w_alu_zero),
        .lt   (w_alu_lt),
        .ltu  (w_alu_ltu)
    );

    // Branches compare against the register operand, not the immediate-muxed SrcB,
    // so a second instance supplies the flags for that pair.
    exec_alu #(.XLEN(XLEN)) u_cmp (
        .a    (w_src_a),
        .b    (w_write_data),
        .op   (ALU_SUB),
        .y    (w_cmp_y),
        .zero (w_eq),
        .lt   (w_lt),
        .ltu  (w_ltu)
    );

    assign w_unused = &{1'b0, w_cmp_y, w_alu_zero, w_alu_lt, w_alu_ltu};

    always_comb begin
        w_taken = 1'b0;
        case (funct3_E)
            BR_EQ:   w_taken = w_eq;
            BR_NE:   w_taken = ~w_eq;
            BR_LT:   w_taken = w_lt;
            BR_GE:   w_taken = ~w_lt;
            BR_LTU:  w_taken = w_ltu;
            BR_GEU:  w_taken = ~w_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_jalr_sum = w_src_a + Imm_Ext_E;
    assign PCSrcE     = JumpE | (BranchE & w_taken);
    assign PCTargetE  = JalrE ? {w_jalr_sum[XLEN-1:1], 1'b0} : (PCE + Imm_Ext_E);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwrite_m  <= 1'b0;
            r_memwrite_m  <= 1'b0;
            r_memread_m   <= 1'b0;
            r_resultsrc_m <= 1'b0;
            r_aluresult_m <= '0;
            r_writedata_m <= '0;
            r_pcplus4_m   <= RESET_PC_M;
            r_rd_m        <= '0;
            r_funct3_m    <= '0;
        end else if (FlushM) begin
            r_regwrite_m  <= 1'b0;
            r_memwrite_m  <= 1'b0;
            r_memread_m   <= 1'b0;
            r_resultsrc_m <= 1'b0;
            r_aluresult_m <= '0;
            r_writedata_m <= '0;
            r_pcplus4_m   <= '0;
            r_rd_m        <= '0;
            r_funct3_m    <= '0;
        end else if (!StallM) begin
            r_regwrite_m  <= RegWriteE;
            r_memwrite_m  <= MemWriteE;
            r_memread_m   <= MemReadE;
            r_resultsrc_m <= ResultSrcE;
            r_aluresult_m <= JumpE ? PCPlus4E : w_alu_y;
            r_writedata_m <= w_write_data;
            r_pcplus4_m   <= PCPlus4E;
            r_rd_m        <= RD_E;
            r_funct3_m    <= funct3_E;
        end
    end

`ifdef EXEC_PERF_CNT_EN
    logic [31:0] r_branch_cnt, r_taken_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else if (BranchE && !StallM) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_taken) r_taken_cnt <= r_taken_cnt + 32'd1;
        end
    end

    assign BranchCnt = r_branch_cnt;
    assign TakenCnt  = r_taken_cnt;
`endif

    assign RegWriteM  = r_regwrite_m;
    assign MemWriteM  = r_memwrite_m;
    assign MemReadM   = r_memread_m;
    assign ResultSrcM = r_resultsrc_m;
    assign ALUResultM = r_aluresult_m;
    assign WriteDataM = r_writedata_m;
    assign PCPlus4M   = r_pcplus4_m;
    assign RD_M       = r_rd_m;
    assign funct3_M   = r_funct3_m;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed-vector bench for execute_cycle; EX/MEM results are checked through a scoreboard queue.
module tb_execute_cycle;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE, BranchE, JumpE, JalrE;
    logic [3:0]  ALUControlE;
    logic [2:0]  funct3_E;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallM, FlushM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, MemReadM, ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RD_M;
    logic [2:0]  funct3_M;
`ifdef EXEC_PERF_CNT_EN
    logic [31:0] BranchCnt, TakenCnt;
`endif

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE),
        .ALUControlE(ALUControlE), .funct3_E(funct3_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RD_E(RD_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .StallM(StallM), .FlushM(FlushM),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RD_M(RD_M), .funct3_M(funct3_M)
`ifdef EXEC_PERF_CNT_EN
        , .BranchCnt(BranchCnt), .TakenCnt(TakenCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, mw, mr, rs;
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic [2:0]  f3;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic rw, mw, mr, rs, input logic [31:0] alu, wd, pc4,
                                input logic [4:0] rd, input logic [2:0] f3);
        exp_t e;
        e.rw = rw; e.mw = mw; e.mr = mr; e.rs = rs;
        e.alu = alu; e.wd = wd; e.pc4 = pc4; e.rd = rd; e.f3 = f3;
        return e;
    endfunction

    // Monitor: the EX/MEM register presents a new value after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("RegWriteM",  {31'b0, RegWriteM},  {31'b0, e.rw});
                chk("MemWriteM",  {31'b0, MemWriteM},  {31'b0, e.mw});
                chk("MemReadM",   {31'b0, MemReadM},   {31'b0, e.mr});
                chk("ResultSrcM", {31'b0, ResultSrcM}, {31'b0, e.rs});
                chk("ALUResultM", ALUResultM, e.alu);
                chk("WriteDataM", WriteDataM, e.wd);
                chk("PCPlus4M",   PCPlus4M,   e.pc4);
                chk("RD_M",       {27'b0, RD_M},     {27'b0, e.rd});
                chk("funct3_M",   {29'b0, funct3_M}, {29'b0, e.f3});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clr();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; MemReadE = 0; ResultSrcE = 0;
        BranchE = 0; JumpE = 0; JalrE = 0; ALUControlE = ALU_ADD; funct3_E = 3'b000;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
        RD_E = 0; ForwardAE = FWD_RD; ForwardBE = FWD_RD; StallM = 0; FlushM = 0;
    endtask

    // Inputs are already applied at a falling edge; check comb outputs, queue the
    // expected EX/MEM content, then advance one cycle back to the falling edge.
    task automatic step(input string name, input exp_t e, input logic pcsrc, input logic [31:0] tgt);
        #1;
        chk({name, ".PCSrcE"},    {31'b0, PCSrcE}, {31'b0, pcsrc});
        chk({name, ".PCTargetE"}, PCTargetE, tgt);
        q.push_back(e);
        last = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    exp_t zero_e;

    initial begin
        zero_e = mk(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0);
        clr();
        rst = 0;
        RegWriteE = 1; MemWriteE = 1; RD1_E = 32'h5; RD2_E = 32'h9; PCPlus4E = 32'h44;
        RD_E = 5'd4; JumpE = 1; PCE = 32'h100; Imm_Ext_E = 32'h8;
        @(negedge clk);
        step("reset", zero_e, 1'b1, 32'h108);
        step("reset2", zero_e, 1'b1, 32'h108);
        rst = 1;

        clr(); RegWriteE = 1; RD1_E = 5; RD2_E = 7; RD_E = 5'd9; funct3_E = 3'b010;
        PCPlus4E = 32'h14; PCE = 32'h10;
        step("add", mk(1, 0, 0, 0, 32'd12, 32'd7, 32'h14, 5'd9, 3'd2), 1'b0, 32'h10);

        clr(); RegWriteE = 1; RD1_E = 60; RD2_E = 40; RD_E = 5'd3;
        step("add100", mk(1, 0, 0, 0, 32'd100, 32'd40, 32'h0, 5'd3, 3'd0), 1'b0, 32'h0);

        clr(); MemWriteE = 1; ALUControlE = ALU_SUB; ForwardAE = FWD_M; ForwardBE = FWD_W;
        ResultW = 3; RD1_E = 32'hDEAD; RD2_E = 32'hBEEF;
        step("fwd_sub", mk(0, 1, 0, 0, 32'd97, 32'd3, 32'h0, 5'd0, 3'd0), 1'b0, 32'h0);

        clr(); ALUControlE = ALU_SUB; ForwardAE = 2'b11; ResultW = 32'h77; RD1_E = 20; RD2_E = 6;
        step("fwd11", mk(0, 0, 0, 0, 32'd14, 32'd6, 32'h0, 5'd0, 3'd0), 1'b0, 32'h0);

        clr(); ALUControlE = ALU_SRA; ALUSrcE = 1; RD1_E = 32'h8000_0000; Imm_Ext_E = 32'h24; RD2_E = 32'h55;
        step("sra", mk(0, 0, 0, 0, 32'hF800_0000, 32'h55, 32'h0, 5'd0, 3'd0), 1'b0, 32'h24);

        clr(); ALUControlE = ALU_SLL; RD1_E = 1; RD2_E = 31;
        step("sll", mk(0, 0, 0, 0, 32'h8000_0000, 32'd31, 32'h0, 5'd0, 3'd0), 1'b0, 32'h0);

        clr(); ALUControlE = ALU_SLT; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
        step("slt", mk(0, 0, 0, 0, 32'h1, 32'h1, 32'h0, 5'd0, 3'd0), 1'b0, 32'h0);

        clr(); ALUControlE = ALU_SLTU; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
        step("sltu", mk(0, 0, 0, 0, 32'h0, 32'h1, 32'h0, 5'd0, 3'd0), 1'b0, 32'h0);

        clr(); ALUControlE = ALU_PASSB; ALUSrcE = 1; Imm_Ext_E = 32'h1234_5000; RD1_E = 32'h9;
        step("passb", mk(0, 0, 0, 0, 32'h1234_5000, 32'h0, 32'h0, 5'd0, 3'd0), 1'b0, 32'h1234_5000);

        clr(); ALUControlE = 4'b1111; RD1_E = 32'h33; RD2_E = 32'h44;
        step("badop", mk(0, 0, 0, 0, 32'h0, 32'h44, 32'h0, 5'd0, 3'd0), 1'b0, 32'h0);

        clr(); BranchE = 1; funct3_E = BR_LT; ALUControlE = ALU_SUB; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
        PCE = 32'h200; Imm_Ext_E = 32'h40;
        step("blt", mk(0, 0, 0, 0, 32'hFFFF_FFFE, 32'h1, 32'h0, 5'd0, 3'd4), 1'b1, 32'h240);

        funct3_E = BR_LTU;
        step("bltu", mk(0, 0, 0, 0, 32'hFFFF_FFFE, 32'h1, 32'h0, 5'd0, 3'd6), 1'b0, 32'h240);

        clr(); BranchE = 1; funct3_E = BR_EQ; ALUControlE = ALU_SUB; ALUSrcE = 1; RD1_E = 5; RD2_E = 6;
        Imm_Ext_E = 5; PCE = 32'h300;
        step("beq_imm", mk(0, 0, 0, 0, 32'h0, 32'h6, 32'h0, 5'd0, 3'd0), 1'b0, 32'h305);

        clr(); BranchE = 1; funct3_E = 3'b010; RD1_E = 8; RD2_E = 8; PCE = 32'h10; Imm_Ext_E = 32'h10;
        step("br010", mk(0, 0, 0, 0, 32'h10, 32'h8, 32'h0, 5'd0, 3'd2), 1'b0, 32'h20);

        clr(); JumpE = 1; JalrE = 1; RegWriteE = 1; ALUSrcE = 1; RD1_E = 32'h1003; Imm_Ext_E = 4;
        PCPlus4E = 32'h20; PCE = 32'h1C; RD_E = 5'd1;
        step("jalr", mk(1, 0, 0, 0, 32'h20, 32'h0, 32'h20, 5'd1, 3'd0), 1'b1, 32'h1006);

        clr(); JumpE = 1; RegWriteE = 1; PCE = 32'h400; PCPlus4E = 32'h404; Imm_Ext_E = 32'h10; RD_E = 5'd1;
        RD1_E = 32'h7;
        step("jal", mk(1, 0, 0, 0, 32'h404, 32'h0, 32'h404, 5'd1, 3'd0), 1'b1, 32'h410);

        clr(); RegWriteE = 1; MemReadE = 1; ResultSrcE = 1; RD1_E = 1; RD2_E = 2; RD_E = 5'd7;
        funct3_E = 3'b010; PCPlus4E = 32'h50;
        step("load", mk(1, 0, 1, 1, 32'h3, 32'h2, 32'h50, 5'd7, 3'd2), 1'b0, 32'h0);

        clr(); StallM = 1; RegWriteE = 0; MemWriteE = 1; RD1_E = 99; RD2_E = 11; RD_E = 5'd30;
        PCPlus4E = 32'h99;
        step("stall1", last, 1'b0, 32'h0);
        step("stall2", last, 1'b0, 32'h0);

        FlushM = 1;
        step("flush", zero_e, 1'b0, 32'h0);

        clr(); RegWriteE = 1; RD1_E = 2; RD2_E = 2; RD_E = 5'd5; PCPlus4E = 32'h60;
        step("preload", mk(1, 0, 0, 0, 32'h4, 32'h2, 32'h60, 5'd5, 3'd0), 1'b0, 32'h0);

        JumpE = 1; PCE = 32'h80; Imm_Ext_E = 32'h4;
        rst = 0;
        #1;
        chk("async_rst.RegWriteM",  {31'b0, RegWriteM}, 32'h0);
        chk("async_rst.ALUResultM", ALUResultM, 32'h0);
        chk("async_rst.PCPlus4M",   PCPlus4M, 32'h0);
        step("in_reset", zero_e, 1'b1, 32'h84);
        rst = 1;

`ifdef EXEC_PERF_CNT_EN
        clr(); BranchE = 1; funct3_E = BR_EQ; RD1_E = 3; RD2_E = 3; PCE = 32'h10; Imm_Ext_E = 32'h8;
        step("perf_beq1", mk(0, 0, 0, 0, 32'h6, 32'h3, 32'h0, 5'd0, 3'd0), 1'b1, 32'h18);
        StallM = 1;
        step("perf_beq2", last, 1'b1, 32'h18);
        StallM = 0; RD2_E = 4;
        step("perf_beq3", mk(0, 0, 0, 0, 32'h7, 32'h4, 32'h0, 5'd0, 3'd0), 1'b0, 32'h18);
        clr(); JumpE = 1;
        step("perf_jal", mk(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0), 1'b1, 32'h0);
        chk("BranchCnt", BranchCnt, 32'd2);
        chk("TakenCnt",  TakenCnt,  32'd1);
`endif

        clr();
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
